// File: rtl/b2bcd_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : b2bcd_serial_ctrl
// Purpose  : Sequential binary-to-BCD converter. One shift-and-add-3
//            (double-dabble) iteration per clock, WIDTH iterations per
//            operand, packed BCD result presented with a one-cycle pulse.
//            Flags operands that do not fit in DIGIT decimal digits.
// Ports    : clk         - clock, rising edge active
//            rst_n       - asynchronous active-low reset
//            in_valid    - operand strobe, sampled only while idle
//            Binary_code - WIDTH-bit binary operand
//            busy        - conversion in progress
//            out_valid   - one-cycle completion pulse
//            BCD_code    - DIGIT*4-bit packed BCD result (digit 0 = LSBs)
//            overflow    - operand was 10^DIGIT or greater
// Revision : 1.0 - initial release
// ============================================================================
module b2bcd_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     Binary_code,
    output logic                 busy,
    output logic                 out_valid,
    output logic [DIGIT*4-1:0]   BCD_code,
    output logic                 overflow
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam int c_bcd_w = DIGIT * 4;

    localparam logic [0:0]         c_st_idle = 1'b0;
    localparam logic [0:0]         c_st_conv = 1'b1;
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);

    logic [0:0]          r_state;
    logic [WIDTH-1:0]    r_bin_sr;
    logic [c_bcd_w-1:0]  r_bcd;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_ovf_acc;

    logic [0:0]          w_state_nxt;
    logic [WIDTH-1:0]    w_bin_nxt;
    logic [c_bcd_w-1:0]  w_bcd_nxt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic                w_ovf_acc_nxt;
    logic [c_bcd_w-1:0]  w_result_nxt;
    logic                w_overflow_nxt;
    logic                w_out_valid_nxt;

    logic [c_bcd_w-1:0]  w_adj;
    logic [c_bcd_w-1:0]  w_shift;
    logic                w_shift_out;

    // Per-digit add-3 correction; digits are independent, no carry between them.
    for (genvar k = 0; k < DIGIT; k++) begin : g_digit
        assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3)
                                                            : r_bcd[4*k +: 4];
    end

    // Corrected BCD shifts left with the next binary MSB entering at bit 0.
    // The bit leaving the top digit is a lost decimal carry: it marks overflow.
    assign w_shift     = {w_adj[c_bcd_w-2:0], r_bin_sr[WIDTH-1]};
    assign w_shift_out = w_adj[c_bcd_w-1];

    assign busy = (r_state == c_st_conv);

    always_comb begin
        w_state_nxt     = r_state;
        w_bin_nxt       = r_bin_sr;
        w_bcd_nxt       = r_bcd;
        w_cnt_nxt       = r_cnt;
        w_ovf_acc_nxt   = r_ovf_acc;
        w_result_nxt    = BCD_code;
        w_overflow_nxt  = overflow;
        w_out_valid_nxt = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    w_bin_nxt     = Binary_code;
                    w_bcd_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_ovf_acc_nxt = 1'b0;
                    w_state_nxt   = c_st_conv;
                end
            end
            c_st_conv: begin
                w_bin_nxt     = r_bin_sr << 1;
                w_bcd_nxt     = w_shift;
                w_ovf_acc_nxt = r_ovf_acc | w_shift_out;
                w_cnt_nxt     = r_cnt + c_cnt_w'(1);
                // Final iteration: publish this iteration's result directly so
                // the output lands on the same edge as the last shift.
                if (r_cnt == c_last) begin
                    w_result_nxt    = w_shift;
                    w_overflow_nxt  = r_ovf_acc | w_shift_out;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_bin_sr  <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            BCD_code  <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bin_sr  <= w_bin_nxt;
            r_bcd     <= w_bcd_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovf_acc <= w_ovf_acc_nxt;
            BCD_code  <= w_result_nxt;
            overflow  <= w_overflow_nxt;
            out_valid <= w_out_valid_nxt;
        end
    end

endmodule
`default_nettype wire
